flex_serializer: RTL and testbench

Parametrised successor to the fixed-width serializer. It converts a parallel word into a serial bitstream with runtime-selectable frame length, bit order and optional parity bit. A one-entry holding buffer with a valid/ready handshake lets the next word load while the current frame shifts, so frames run back-to-back. It sits between the TX control FSM and the line mux, and replaces the fixed 8-bit LSB-first serializer.

---
 rtl/flex_serializer.sv | 136 +++++++++++++
 tb/tb_flex_serializer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flex_serializer.sv
// Parallel-to-serial converter with runtime frame length, bit order and parity.
// A one-word holding slot lets the next word load while the current frame shifts.
module flex_serializer #(
  parameter int   DATA_WIDTH = 8,
  parameter int   LEN_W      = $clog2(DATA_WIDTH) + 1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] DATA,
  input  logic                  Data_Valid,
  output logic                  Data_Ready,
  input  logic [LEN_W-1:0]      Frame_Len,
  input  logic                  Msb_First,
  input  logic                  Par_En,
  input  logic                  Par_Odd,
  input  logic                  Enable,
  output logic                  ser_out,
  output logic                  ser_valid,
  output logic                  ser_done,
  output logic                  Busy,
  output logic [1:0]            state_dbg
);

  // Handshake: a word transfers on a rising CLK edge where Data_Valid && Data_Ready;
  // the producer keeps DATA and the frame controls stable until that edge.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_WIDTH);

  state_t                  state;
  logic                    hold_full;
  logic [DATA_WIDTH-1:0]   hold_data;
  logic [LEN_W-1:0]        hold_len;
  logic                    hold_msb;
  logic                    hold_pen;
  logic                    hold_par;

  logic [DATA_WIDTH-1:0]   sh;
  logic [LEN_W-1:0]        cnt;
  logic [LEN_W-1:0]        len_r;
  logic                    msb_r;
  logic                    pen_r;
  logic                    par_r;

  logic [LEN_W-1:0]        len_eff;
  logic [DATA_WIDTH-1:0]   mask;
  logic [DATA_WIDTH-1:0]   masked;
  logic [DATA_WIDTH-1:0]   aligned;
  logic                    par_calc;
  logic                    last_bit;
  logic                    load;

  // Words are masked, parity-computed and aligned as they enter the slot, so the
  // shifter only ever moves toward its output end.
  always_comb begin
    len_eff  = (Frame_Len == '0 || Frame_Len > FULL_LEN) ? FULL_LEN : Frame_Len;
    mask     = {DATA_WIDTH{1'b1}} >> (FULL_LEN - len_eff);
    masked   = DATA & mask;
    par_calc = (^masked) ^ Par_Odd;
    aligned  = Msb_First ? (masked << (FULL_LEN - len_eff)) : masked;
  end

  assign last_bit   = (cnt == len_r - LEN_W'(1));
  assign ser_done   = (state == S_DATA && last_bit && !pen_r) || (state == S_PARITY);
  assign load       = hold_full && (state == S_IDLE || (ser_done && Enable));
  assign Data_Ready = !hold_full;
  assign ser_valid  = (state != S_IDLE);
  assign Busy       = (state != S_IDLE) || hold_full;
  assign state_dbg  = state;

  always_comb begin
    ser_out = IDLE_LEVEL;
    if (state == S_DATA)
      ser_out = msb_r ? sh[DATA_WIDTH-1] : sh[0];
    else if (state == S_PARITY)
      ser_out = par_r;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_len  <= '0;
      hold_msb  <= 1'b0;
      hold_pen  <= 1'b0;
      hold_par  <= 1'b0;
      sh        <= '0;
      cnt       <= '0;
      len_r     <= '0;
      msb_r     <= 1'b0;
      pen_r     <= 1'b0;
      par_r     <= 1'b0;
    end else begin
      if (Data_Valid && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= aligned;
        hold_len  <= len_eff;
        hold_msb  <= Msb_First;
        hold_pen  <= Par_En;
        hold_par  <= par_calc;
      end

      if (load) begin
        hold_full <= 1'b0;
        state     <= S_DATA;
        sh        <= hold_data;
        cnt       <= '0;
        len_r     <= hold_len;
        msb_r     <= hold_msb;
        pen_r     <= hold_pen;
        par_r     <= hold_par;
      end else if (Enable) begin
        case (state)
          S_DATA: begin
            if (last_bit) begin
              state <= pen_r ? S_PARITY : S_IDLE;
            end else begin
              sh  <= msb_r ? (sh << 1) : (sh >> 1);
              cnt <= cnt + LEN_W'(1);
            end
          end
          S_PARITY: state <= S_IDLE;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flex_serializer.sv
// Bench for flex_serializer: expected {done,bit} pairs are queued when a word is
// offered and popped by a monitor on every falling edge where a bit is consumed.
module tb_flex_serializer;

  localparam int DW = 8;
  localparam int LW = 4;

  logic          CLK;
  logic          RST;
  logic [DW-1:0] DATA;
  logic          Data_Valid;
  logic          Data_Ready;
  logic [LW-1:0] Frame_Len;
  logic          Msb_First;
  logic          Par_En;
  logic          Par_Odd;
  logic          Enable;
  logic          ser_out;
  logic          ser_valid;
  logic          ser_done;
  logic          Busy;
  logic [1:0]    state_dbg;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int valid_cnt = 0;
  int valid_starts = 0;
  logic prev_valid = 1'b0;

  logic [1:0] exp_q[$];

  flex_serializer #(.DATA_WIDTH(DW), .LEN_W(LW), .IDLE_LEVEL(1'b1)) dut (
    .CLK(CLK), .RST(RST), .DATA(DATA), .Data_Valid(Data_Valid),
    .Data_Ready(Data_Ready), .Frame_Len(Frame_Len), .Msb_First(Msb_First),
    .Par_En(Par_En), .Par_Odd(Par_Odd), .Enable(Enable), .ser_out(ser_out),
    .ser_valid(ser_valid), .ser_done(ser_done), .Busy(Busy), .state_dbg(state_dbg)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // scoreboard monitor
  always @(negedge CLK) begin
    if (RST) begin
      if (ser_valid) valid_cnt++;
      if (ser_valid && !prev_valid) valid_starts++;
      prev_valid = ser_valid;
      if (ser_valid && Enable) begin
        logic [1:0] exp_v;
        chk_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_underflow: got bit=%0b done=%0b, required no frame bit", ser_out, ser_done);
        end else begin
          exp_v = exp_q.pop_front();
          if ({ser_done, ser_out} !== exp_v)
            $display("FAIL sb_bit: got done,bit=%b, required %b", {ser_done, ser_out}, exp_v);
          else
            pass_cnt++;
        end
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  // expected-frame model
  task automatic push_frame(input logic [DW-1:0] d, input logic [LW-1:0] len,
                            input logic msb, input logic pe, input logic po);
    int eff;
    logic p, b;
    eff = (len == 0 || len > DW) ? DW : int'(len);
    p = po;
    for (int i = 0; i < eff; i++) begin
      b = msb ? d[eff-1-i] : d[i];
      p = p ^ b;
      exp_q.push_back({(i == eff - 1) && !pe, b});
    end
    if (pe) exp_q.push_back({1'b1, p});
  endtask

  // driver: offer a word and hold it until the handshake edge
  task automatic send_word(input logic [DW-1:0] d, input logic [LW-1:0] len,
                           input logic msb, input logic pe, input logic po);
    bit done;
    done = 0;
    @(negedge CLK);
    DATA = d; Frame_Len = len; Msb_First = msb; Par_En = pe; Par_Odd = po;
    Data_Valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (Data_Ready) begin
        push_frame(d, len, msb, pe, po);
        @(posedge CLK);
        #1;
        done = 1;
      end else begin
        @(negedge CLK);
      end
    end
    Data_Valid = 1'b0;
    if (!done) begin
      chk_cnt++;
      $display("FAIL send_timeout: got Data_Ready=0 for 200 cycles, required acceptance");
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge CLK);
      if (!Busy && exp_q.size() == 0) ok = 1;
    end
    if (!ok) begin
      chk_cnt++;
      $display("FAIL %s_idle_timeout: got Busy=%0b pending=%0d, required idle", name, Busy, exp_q.size());
    end
  endtask

  task automatic check_idle_outputs(input string name);
    chk_cnt++;
    if ({ser_out, ser_valid, ser_done, Busy, Data_Ready} !== 5'b10001)
      $display("FAIL %s: got out,valid,done,busy,ready=%b, required 10001", name,
               {ser_out, ser_valid, ser_done, Busy, Data_Ready});
    else pass_cnt++;
  endtask

  task automatic test_reset();
    RST = 1'b0; Data_Valid = 1'b0; DATA = '0; Frame_Len = '0; Msb_First = 1'b0;
    Par_En = 1'b0; Par_Odd = 1'b0; Enable = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_idle_outputs("reset_during");
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_idle_outputs("reset_after");
  endtask

  task automatic test_basic();
    valid_cnt = 0;
    send_word(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0);
    wait_idle("basic");
    chk_cnt++;
    if (valid_cnt !== 8) $display("FAIL basic_valid_len: got %0d cycles, required 8", valid_cnt);
    else pass_cnt++;
    check_idle_outputs("basic_end");
  endtask

  task automatic test_length_order();
    send_word(8'hF3, 4'd5, 1'b1, 1'b0, 1'b0);
    wait_idle("len5_msb");
    valid_cnt = 0;
    send_word(8'h80, 4'd0, 1'b1, 1'b0, 1'b0);
    wait_idle("len0_msb");
    chk_cnt++;
    if (valid_cnt !== 8) $display("FAIL len0_valid_len: got %0d cycles, required 8", valid_cnt);
    else pass_cnt++;
    send_word(8'hFF, 4'd12, 1'b0, 1'b1, 1'b0);
    wait_idle("len_over");
    send_word(8'h6B, 4'd3, 1'b0, 1'b1, 1'b1);
    wait_idle("len3_par");
  endtask

  task automatic test_parity();
    send_word(8'hA5, 4'd8, 1'b0, 1'b1, 1'b0);
    wait_idle("par_even");
    send_word(8'hA5, 4'd8, 1'b0, 1'b1, 1'b1);
    wait_idle("par_odd");
  endtask

  task automatic test_back_to_back();
    valid_cnt = 0; valid_starts = 0;
    send_word(8'h0F, 4'd8, 1'b0, 1'b0, 1'b0);
    send_word(8'hF0, 4'd8, 1'b0, 1'b0, 1'b0);
    chk_cnt++;
    if (Data_Ready !== 1'b0) $display("FAIL b2b_ready: got %0b, required 0", Data_Ready);
    else pass_cnt++;
    wait_idle("b2b");
    chk_cnt++;
    if (valid_cnt !== 16) $display("FAIL b2b_valid_len: got %0d cycles, required 16", valid_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (valid_starts !== 1) $display("FAIL b2b_gap: got %0d valid runs, required 1", valid_starts);
    else pass_cnt++;
  endtask

  task automatic test_random_b2b();
    logic [DW-1:0] d;
    logic [LW-1:0] l;
    for (int k = 0; k < 6; k++) begin
      d = DW'($urandom_range(0, 255));
      l = LW'($urandom_range(0, 9));
      send_word(d, l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    wait_idle("rand");
  endtask

  task automatic test_stall();
    logic pat[7];
    bit seen;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    seen = 0;
    Enable = 1'b1;
    send_word(8'h5A, 4'd8, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100 && !seen; i++) begin
      Enable = pat[i % 7];
      @(posedge CLK);
      #1;
      if (ser_done) seen = 1;
    end
    Enable = 1'b0;
    chk_cnt++;
    if (!seen) $display("FAIL stall_done_seen: got no ser_done, required one");
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      chk_cnt++;
      if ({ser_valid, ser_done, ser_out} !== 3'b110)
        $display("FAIL stall_hold: got valid,done,out=%b, required 110", {ser_valid, ser_done, ser_out});
      else pass_cnt++;
    end
    Enable = 1'b1;
    wait_idle("stall");
  endtask

  task automatic test_reset_mid();
    send_word(8'hFF, 4'd8, 1'b0, 1'b0, 1'b0);
    send_word(8'h00, 4'd8, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    chk_cnt++;
    if ({ser_valid, Data_Ready} !== 2'b10)
      $display("FAIL mid_pre: got valid,ready=%b, required 10", {ser_valid, Data_Ready});
    else pass_cnt++;
    RST = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    exp_q.delete();
    @(negedge CLK);
    #1;
    RST = 1'b1;
    send_word(8'h3C, 4'd8, 1'b0, 1'b0, 1'b0);
    wait_idle("after_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_length_order();
    test_parity();
    test_back_to_back();
    test_stall();
    test_random_b2b();
    test_reset_mid();
    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
